// File: rtl/alu_operand_seq.sv
// Sequential operand loader and result capture around the board ALU.
// Optional macro ALU_SEQ_DEBOUNCE_EN adds a button debouncer of DEB_CYCLES.
module alu_operand_seq #(
    parameter int W          = 4,
    parameter int OPW        = 3,
    parameter int DEB_CYCLES = 250000
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [W-1:0]   sw,
    input  logic           btn,
    input  logic           clr,
    input  logic [W-1:0]   alu_result,
    input  logic           alu_overflow,
    input  logic           alu_zero,
    input  logic           alu_carry,
    output logic [W-1:0]   op_a,
    output logic [W-1:0]   op_b,
    output logic [OPW-1:0] op_code,
    output logic [W-1:0]   res,
    output logic [2:0]     flags,
    output logic           res_valid,
    output logic [2:0]     state
);

    // state  | meaning
    // S_A    | waiting for step to load operand A
    // S_B    | waiting for step to load operand B
    // S_OP   | waiting for step to load opcode
    // S_EXEC | one cycle, ALU settled, capture on exit
    // S_SHOW | result on display, step restarts
    typedef enum logic [2:0] {
        S_A    = 3'd0,
        S_B    = 3'd1,
        S_OP   = 3'd2,
        S_EXEC = 3'd3,
        S_SHOW = 3'd4
    } state_t;

    logic btn_s1_q, btn_s2_q, btn_prev_q;
    logic btn_lvl;
    logic step;

`ifdef ALU_SEQ_DEBOUNCE_EN
    localparam int CW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    logic [CW-1:0] deb_cnt_q, deb_cnt_d;
    logic          deb_q, deb_d;

    // Down-counter reloads whenever the input agrees; flip on terminal count.
    always_comb begin
        deb_d     = deb_q;
        deb_cnt_d = deb_cnt_q;
        if (btn_s2_q == deb_q) begin
            deb_cnt_d = CW'(DEB_CYCLES - 1);
        end else if (deb_cnt_q == '0) begin
            deb_d     = btn_s2_q;
            deb_cnt_d = CW'(DEB_CYCLES - 1);
        end else begin
            deb_cnt_d = deb_cnt_q - CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            deb_q     <= 1'b0;
            deb_cnt_q <= '0;
        end else begin
            deb_q     <= deb_d;
            deb_cnt_q <= deb_cnt_d;
        end
    end

    assign btn_lvl = deb_q;
`else
    assign btn_lvl = btn_s2_q;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            btn_s1_q   <= 1'b0;
            btn_s2_q   <= 1'b0;
            btn_prev_q <= 1'b0;
        end else begin
            btn_s1_q   <= btn;
            btn_s2_q   <= btn_s1_q;
            btn_prev_q <= btn_lvl;
        end
    end

    assign step = btn_lvl & ~btn_prev_q;

    state_t         state_q, state_d;
    logic [W-1:0]   op_a_q, op_a_d, op_b_q, op_b_d, res_q, res_d;
    logic [OPW-1:0] op_code_q, op_code_d;
    logic [2:0]     flags_q, flags_d;
    logic           res_valid_q, res_valid_d;

    always_comb begin
        state_d     = state_q;
        op_a_d      = op_a_q;
        op_b_d      = op_b_q;
        op_code_d   = op_code_q;
        res_d       = res_q;
        flags_d     = flags_q;
        res_valid_d = res_valid_q;
        if (clr) begin
            state_d     = S_A;
            op_a_d      = '0;
            op_b_d      = '0;
            op_code_d   = '0;
            res_d       = '0;
            flags_d     = '0;
            res_valid_d = 1'b0;
        end else begin
            case (state_q)
                S_A: if (step) begin
                    op_a_d  = sw;
                    state_d = S_B;
                end
                S_B: if (step) begin
                    op_b_d  = sw;
                    state_d = S_OP;
                end
                S_OP: if (step) begin
                    op_code_d = OPW'(sw);
                    state_d   = S_EXEC;
                end
                // Step is ignored here; the ALU output is already valid.
                S_EXEC: begin
                    res_d       = alu_result;
                    flags_d     = {alu_overflow, alu_zero, alu_carry};
                    res_valid_d = 1'b1;
                    state_d     = S_SHOW;
                end
                S_SHOW: if (step) begin
                    res_valid_d = 1'b0;
                    state_d     = S_A;
                end
                default: state_d = S_A;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_A;
            op_a_q      <= '0;
            op_b_q      <= '0;
            op_code_q   <= '0;
            res_q       <= '0;
            flags_q     <= '0;
            res_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            op_a_q      <= op_a_d;
            op_b_q      <= op_b_d;
            op_code_q   <= op_code_d;
            res_q       <= res_d;
            flags_q     <= flags_d;
            res_valid_q <= res_valid_d;
        end
    end

    assign op_a      = op_a_q;
    assign op_b      = op_b_q;
    assign op_code   = op_code_q;
    assign res       = res_q;
    assign flags     = flags_q;
    assign res_valid = res_valid_q;
    assign state     = state_q;

endmodule

// File: tb/tb_alu_operand_seq.sv
// Randomized scoreboard bench for alu_operand_seq with a behavioural ALU and sequence model.
module tb_alu_operand_seq;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] sw;
    logic       btn;
    logic       clr;
    logic [3:0] alu_result;
    logic       alu_overflow, alu_zero, alu_carry;
    logic [3:0] op_a, op_b, res;
    logic [2:0] op_code, flags, state;
    logic       res_valid;

    alu_operand_seq dut (
        .clk(clk), .rst_n(rst_n), .sw(sw), .btn(btn), .clr(clr),
        .alu_result(alu_result), .alu_overflow(alu_overflow),
        .alu_zero(alu_zero), .alu_carry(alu_carry),
        .op_a(op_a), .op_b(op_b), .op_code(op_code), .res(res),
        .flags(flags), .res_valid(res_valid), .state(state)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    typedef struct {
        logic [3:0] a, b;
        logic [2:0] op;
        logic [3:0] r;
        logic [2:0] f;
    } exp_t;
    exp_t sb_q[$];

    // Board ALU: result zeroed on signed overflow, zero flag from the raw result.
    function automatic logic [6:0] alu_ref(input logic [3:0] a, input logic [3:0] b, input logic [2:0] op);
        int         sa, sb, sr;
        int         ua, ub, ur;
        logic [3:0] r;
        logic       ov, z, c;
        sa = a[3] ? int'(a) - 16 : int'(a);
        sb = b[3] ? int'(b) - 16 : int'(b);
        ua = int'(a);
        ub = int'(b);
        ov = 1'b0;
        c  = 1'b0;
        case (op)
            3'd0: begin ur = ua + ub; sr = sa + sb; c = (ur > 15); ov = (sr > 7) || (sr < -8); r = 4'(ur); end
            3'd1: begin ur = ua - ub; sr = sa - sb; c = (ur < 0);  ov = (sr > 7) || (sr < -8); r = 4'(ur); end
            3'd2: r = a & b;
            3'd3: r = a | b;
            3'd4: r = a ^ b;
            3'd5: r = ~a;
            3'd6: begin r = 4'(ua * 2); c = (ua >= 8); end
            default: begin r = 4'(ua / 2); c = (ua % 2) == 1; end
        endcase
        z = (r == 4'd0);
        if (ov) r = 4'd0;
        return {r, ov, z, c};
    endfunction

    always_comb begin
        {alu_result, alu_overflow, alu_zero, alu_carry} = alu_ref(op_a, op_b, op_code);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Monitor: each fresh capture pops one expectation.
    logic rv_prev = 1'b0;
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && res_valid && !rv_prev) begin
            if (sb_q.size() == 0) begin
                n_checks++;
                $display("FAIL sb_unexpected: capture res=%0h with no expectation queued", res);
            end else begin
                e = sb_q.pop_front();
                check("sb_res",   32'(res),     32'(e.r));
                check("sb_flags", 32'(flags),   32'(e.f));
                check("sb_op_a",  32'(op_a),    32'(e.a));
                check("sb_op_b",  32'(op_b),    32'(e.b));
                check("sb_op",    32'(op_code), 32'(e.op));
                check("sb_state", 32'(state),   32'd4);
            end
        end
        rv_prev <= res_valid;
    end

    task automatic press(input logic [3:0] v, input int hold);
        @(negedge clk);
        sw  = v;
        btn = 1'b1;
        repeat (hold) @(negedge clk);
        btn = 1'b0;
        repeat (5) @(negedge clk);
    endtask

    task automatic wait_valid();
        for (int i = 0; i < 20 && !res_valid; i++) @(negedge clk);
        check("res_valid_rise", 32'(res_valid), 32'd1);
    endtask

    task automatic run_seq(input logic [3:0] a, input logic [3:0] b, input logic [2:0] op, input int hold);
        exp_t       e;
        logic [6:0] m;
        press(a, hold);
        check("load_a_state", 32'(state), 32'd1);
        check("load_a_val",   32'(op_a),  32'(a));
        press(b, hold);
        check("load_b_state", 32'(state), 32'd2);
        check("load_b_val",   32'(op_b),  32'(b));
        m    = alu_ref(a, b, op);
        e.a  = a; e.b = b; e.op = op; e.r = m[6:3]; e.f = m[2:0];
        sb_q.push_back(e);
        press({$urandom_range(0, 1) == 1, op}, hold);
        wait_valid();
    endtask

    task automatic leave_show(input logic [3:0] exp_res, input int hold);
        press(4'($urandom), hold);
        check("show_exit_state", 32'(state),     32'd0);
        check("show_exit_valid", 32'(res_valid), 32'd0);
        check("show_keep_res",   32'(res),       32'(exp_res));
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time budget");
        $fatal(1, "timeout");
    end

    initial begin
        logic [3:0] a, b, r_keep;
        logic [2:0] op;
        logic [6:0] m;
        rst_n = 1'b0; btn = 1'b0; clr = 1'b0; sw = 4'h0;
        #2;
        check("rst_state", 32'(state), 32'd0);
        check("rst_valid", 32'(res_valid), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        run_seq(4'h3, 4'h2, 3'd0, 1);
        check("add_res",   32'(res),   32'h5);
        check("add_flags", 32'(flags), 32'h0);
        leave_show(4'h5, 2);

        run_seq(4'h7, 4'h1, 3'd0, 1);
        check("ovf_res",   32'(res),   32'h0);
        check("ovf_flags", 32'(flags), 32'h4);
        leave_show(4'h0, 1);

        // Held button: exactly one step, later sw changes ignored.
        press(4'h9, 100);
        check("held_state", 32'(state), 32'd1);
        check("held_op_a",  32'(op_a),  32'h9);
        sw = 4'h6;
        repeat (10) @(negedge clk);
        check("held_stay", 32'(state), 32'd1);
        check("sw_no_effect", 32'(op_a), 32'h9);
        press(4'h4, 3);
        m = alu_ref(4'h9, 4'h4, 3'd4);
        sb_q.push_back('{a: 4'h9, b: 4'h4, op: 3'd4, r: m[6:3], f: m[2:0]});
        press(4'h4, 3);
        wait_valid();

        // clr together with step in S_SHOW.
        @(negedge clk);
        sw = 4'hA; clr = 1'b1; btn = 1'b1;
        @(negedge clk);
        btn = 1'b0;
        repeat (4) @(negedge clk);
        clr = 1'b0;
        repeat (3) @(negedge clk);
        check("clr_state", 32'(state),     32'd0);
        check("clr_op_a",  32'(op_a),      32'd0);
        check("clr_op_b",  32'(op_b),      32'd0);
        check("clr_op",    32'(op_code),   32'd0);
        check("clr_res",   32'(res),       32'd0);
        check("clr_flags", 32'(flags),     32'd0);
        check("clr_valid", 32'(res_valid), 32'd0);

        // Bouncing button without debounce: each rising bounce is a step.
        @(negedge clk);
        sw = 4'hC; btn = 1'b1;
        repeat (3) @(negedge clk);
        btn = 1'b0;
        repeat (3) @(negedge clk);
        btn = 1'b1;
        repeat (5) @(negedge clk);
        btn = 1'b0;
        repeat (5) @(negedge clk);
        check("bounce_state", 32'(state), 32'd2);
        check("bounce_op_a",  32'(op_a),  32'hC);
        check("bounce_op_b",  32'(op_b),  32'hC);
        m = alu_ref(4'hC, 4'hC, 3'd1);
        sb_q.push_back('{a: 4'hC, b: 4'hC, op: 3'd1, r: m[6:3], f: m[2:0]});
        press(4'h1, 2);
        wait_valid();
        leave_show(m[6:3], 1);

        for (int i = 0; i < 15; i++) begin
            a  = 4'($urandom);
            b  = 4'($urandom);
            op = 3'($urandom);
            m  = alu_ref(a, b, op);
            run_seq(a, b, op, $urandom_range(1, 8));
            leave_show(m[6:3], $urandom_range(1, 8));
        end

        // Leave a nonzero capture, then reset asynchronously mid-S_OP.
        run_seq(4'h2, 4'h2, 3'd0, 1);
        r_keep = res;
        check("pre_rst_res", 32'(r_keep), 32'h4);
        leave_show(4'h4, 1);
        press(4'h5, 1);
        press(4'h6, 1);
        check("pre_rst_state", 32'(state), 32'd2);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("arst_state", 32'(state),     32'd0);
        check("arst_op_a",  32'(op_a),      32'd0);
        check("arst_op_b",  32'(op_b),      32'd0);
        check("arst_op",    32'(op_code),   32'd0);
        check("arst_res",   32'(res),       32'd0);
        check("arst_flags", 32'(flags),     32'd0);
        check("arst_valid", 32'(res_valid), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("sb_drained", 32'(sb_q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/alu_operand_seq.md
Name: alu_operand_seq

Overview:
- Sequential front-end/back-end wrapper for the 4-bit ALU in the board experiment design.
- Loads operand A, operand B and the 3-bit opcode one at a time from the slide switches, stepping with a single push button.
- Drives the ALU inputs from registers and captures the ALU result and flags into a registered result stage for the display logic.
- Sits between the board I/O (switches, button) and the ALU upstream, and between the ALU and the 7-segment/LED drivers downstream.

Parameters:
- W, 4, operand/result width.
- OPW, 3, opcode width.
- DEB_CYCLES, 250000, stable-cycle count for the button debouncer (used only with the optional feature).

Ports:
- clk  input  1  system clock.
- rst_n  input  1  asynchronous active-low reset.
- sw  input  W  slide switches; operand or opcode source.
- btn  input  1  raw step button, active-high, asynchronous to clk.
- clr  input  1  synchronous restart, active-high, level-sampled.
- alu_result  input  W  ALU Result.
- alu_overflow  input  1  ALU Overflow flag.
- alu_zero  input  1  ALU Zero flag.
- alu_carry  input  1  ALU Carry flag.
- op_a  output  W  registered operand A to the ALU.
- op_b  output  W  registered operand B to the ALU.
- op_code  output  OPW  registered opcode to the ALU.
- res  output  W  captured result.
- flags  output  3  captured {overflow, zero, carry}.
- res_valid  output  1  high while res/flags hold a fresh capture.
- state  output  3  current state encoding, for LEDs.

Behaviour:
- Reset (rst_n low, asynchronous):
  - state = S_A; op_a, op_b, op_code, res, flags = 0; res_valid = 0.
  - Synchronizer and edge registers = 0.
- Button path:
  - btn passes through a 2-flop synchronizer, then a rising-edge detector.
  - The result is `step`, a one-cycle pulse.
  - Latency: step is high in the 3rd clk edge after btn is sampled high.
  - A held button produces exactly one step.
- States (encoding): S_A=0, S_B=1, S_OP=2, S_EXEC=3, S_SHOW=4. Encodings 5-7 are illegal and return to S_A next cycle.
- S_A: on step, op_a <= sw, go to S_B.
- S_B: on step, op_b <= sw, go to S_OP.
- S_OP: on step, op_code <= sw[OPW-1:0], go to S_EXEC.
- S_EXEC:
  - Lasts exactly one cycle and does not wait for step.
  - The ALU is combinational from the op registers, so its outputs are valid during this cycle.
  - On exit: res <= alu_result, flags <= {alu_overflow, alu_zero, alu_carry}, res_valid <= 1, go to S_SHOW.
  - A step arriving in S_EXEC is discarded.
- S_SHOW:
  - Holds all registers.
  - On step: res_valid <= 0, go to S_A.
  - res and flags keep their old values until the next S_EXEC capture.
  - op_a, op_b and op_code keep their values until overwritten in their own state.
- clr:
  - Checked before step in every state.
  - clr high at a clk edge forces state = S_A and res_valid = 0, and clears op_a, op_b, op_code, res and flags to 0.
  - A simultaneous step is ignored.
- Captured data is stored as-is. res is stored as delivered; the ALU already zeroes Result on overflow.
- sw changes outside a loading step have no effect.
- rst_n asserted mid-sequence aborts immediately to the reset values. No partial operand survives.

Optional Feature:
- Macro: ALU_SEQ_DEBOUNCE_EN.
- Defined:
  - A debounce counter sits between the synchronizer and the edge detector.
  - The debounced level changes only after the synchronized btn differs from it for DEB_CYCLES consecutive cycles; the counter restarts on any bounce.
  - step latency = 3 + DEB_CYCLES cycles.
  - Counter and debounced level reset to 0.
- Undefined: no counter. step latency is 3 cycles, and every synchronized rising edge produces a step.

Test Plan:
- Reset with rst_n=0 mid-S_OP -> state=0, op_a=op_b=op_code=res=flags=0, res_valid=0 immediately, without waiting for a clk edge.
- Load A: sw=4'h3 then step; B: sw=4'h2 then step; op: sw=3'b000 then step -> ALU model returns 4'h5, flags 000. res=4'h5 and res_valid=1 one cycle after S_EXEC, state=4.
- Load A=4'h7, B=4'h1, op=3'b000 with the model returning overflow=1, result=0 -> res=0, flags=3'b100, res_valid=1.
- btn held high for 100 cycles in S_A -> exactly one transition to S_B; op_a equals sw at the step cycle.
- In S_SHOW, assert clr and step on the same edge -> state=0, all data registers 0, res_valid=0. No S_A load occurs.
- With ALU_SEQ_DEBOUNCE_EN and DEB_CYCLES=8: btn bounces 1-0-1 at 3-cycle spacing, then stays high -> a single step, issued 3+8 cycles after the last rising bounce. Without the macro, each bounce produces a step.
